// File: rtl/quadrature_rate_counter.sv
// quadrature_rate_counter: windowed, saturating x1/x2/x4 quadrature edge counter; optional input glitch filter via QRC_FILTER_EN
module quadrature_rate_counter #(
  parameter int COUNT_WIDTH   = 16,
  parameter int WINDOW_CYCLES = 100000,
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_CYCLES   = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_Channel_A,
  input  logic                          i_Channel_B,
  input  logic                          i_Enable,
  input  logic [1:0]                    i_Mode,
  output logic signed [COUNT_WIDTH-1:0] o_Count,
  output logic                          o_Direction,
  output logic                          o_Overflow,
  output logic                          o_Error,
  output logic                          o_Data_Valid
);
  localparam int WW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic signed [COUNT_WIDTH-1:0] MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] MIN = ~MAX;
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0] raw, ab, ab_prev, chg;
  logic [WW-1:0] wcnt;
  logic signed [COUNT_WIDTH-1:0] acc, acc_next;
  logic ovf_w, err_w, active, illegal, fwd, step, sat, last;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], i_Channel_A};
      b_sync <= {b_sync[SYNC_STAGES-2:0], i_Channel_B};
    end
  end
  assign raw = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
`ifdef QRC_FILTER_EN
  localparam int FW = $clog2(FILT_CYCLES + 1);
  logic [FW-1:0] fcnt_a, fcnt_b;
  logic filt_a, filt_b;
  // a new level is accepted only after FILT_CYCLES consecutive samples disagree with the held one
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      fcnt_a <= '0;
      fcnt_b <= '0;
      filt_a <= 1'b0;
      filt_b <= 1'b0;
    end else begin
      fcnt_a <= (raw[1] == filt_a || fcnt_a == FW'(FILT_CYCLES - 1)) ? '0 : fcnt_a + FW'(1);
      fcnt_b <= (raw[0] == filt_b || fcnt_b == FW'(FILT_CYCLES - 1)) ? '0 : fcnt_b + FW'(1);
      if (raw[1] != filt_a && fcnt_a == FW'(FILT_CYCLES - 1)) filt_a <= raw[1];
      if (raw[0] != filt_b && fcnt_b == FW'(FILT_CYCLES - 1)) filt_b <= raw[0];
    end
  end
  assign ab = {filt_a, filt_b};
`else
  assign ab = raw;
`endif
  // for a single-bit change on the 00->10->11->01 cycle, old B xor new A marks forward motion
  always_comb begin
    chg      = ab ^ ab_prev;
    active   = (state == COUNT) && i_Enable;
    illegal  = &chg;
    fwd      = ab_prev[0] ^ ab[1];
    step     = active && (^chg) &&
               (i_Mode == 2'b00 ? (chg[1] && ab[1]) : i_Mode == 2'b01 ? chg[1] : 1'b1);
    sat      = step && (fwd ? acc == MAX : acc == MIN);
    acc_next = (step && !sat) ? (fwd ? acc + COUNT_WIDTH'(1) : acc - COUNT_WIDTH'(1)) : acc;
    last     = wcnt == WW'(WINDOW_CYCLES - 1);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      acc          <= '0;
      ovf_w        <= 1'b0;
      err_w        <= 1'b0;
      ab_prev      <= '0;
      o_Count      <= '0;
      o_Direction  <= 1'b1;
      o_Overflow   <= 1'b0;
      o_Error      <= 1'b0;
      o_Data_Valid <= 1'b0;
    end else begin
      ab_prev      <= ab;
      o_Data_Valid <= 1'b0;
      if (step) o_Direction <= fwd;
      if (!active || last) begin
        wcnt  <= '0;
        acc   <= '0;
        ovf_w <= 1'b0;
        err_w <= 1'b0;
        state <= i_Enable ? COUNT : IDLE;
      end else begin
        wcnt  <= wcnt + WW'(1);
        acc   <= acc_next;
        ovf_w <= ovf_w | sat;
        err_w <= err_w | illegal;
      end
      if (active && last) begin
        o_Count      <= acc_next;
        o_Overflow   <= ovf_w | sat;
        o_Error      <= err_w | illegal;
        o_Data_Valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_quadrature_rate_counter.sv
// tb_quadrature_rate_counter: directed checks on an 8-bit and a 5-bit counter sharing the same encoder pins
module tb_quadrature_rate_counter;
  logic clk = 1'b0, rst, a, b, en;
  logic [1:0] mode;
  logic signed [7:0] cnt8;
  logic signed [4:0] cnt5;
  logic dir8, ovf8, err8, dv8, dir5, ovf5, err5, dv5;
  int checks = 0, errors = 0, p = 0, n, seen;
  always #5 clk = ~clk;
  quadrature_rate_counter #(.COUNT_WIDTH(8), .WINDOW_CYCLES(100), .SYNC_STAGES(2), .FILT_CYCLES(4)) u_main (
    .i_Clk(clk), .i_Reset(rst), .i_Channel_A(a), .i_Channel_B(b), .i_Enable(en), .i_Mode(mode),
    .o_Count(cnt8), .o_Direction(dir8), .o_Overflow(ovf8), .o_Error(err8), .o_Data_Valid(dv8));
  quadrature_rate_counter #(.COUNT_WIDTH(5), .WINDOW_CYCLES(100), .SYNC_STAGES(2), .FILT_CYCLES(4)) u_sat (
    .i_Clk(clk), .i_Reset(rst), .i_Channel_A(a), .i_Channel_B(b), .i_Enable(en), .i_Mode(mode),
    .o_Count(cnt5), .o_Direction(dir5), .o_Overflow(ovf5), .o_Error(err5), .o_Data_Valid(dv5));
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic set_phase;
    a = (p == 1) || (p == 2);
    b = (p == 2) || (p == 3);
  endtask
  task automatic steps(input bit fw, input int cnt, input int hold);
    for (int i = 0; i < cnt; i++) begin
      p = fw ? (p + 1) % 4 : (p + 3) % 4;
      set_phase();
      tick(hold);
    end
  endtask
  task automatic wait_dv(output int w);
    w = 0;
    do begin
      tick(1);
      w++;
    end while (!dv8 && w < 300);
    chk("dv_seen", dv8, 1);
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b10; a = 1'b0; b = 1'b0;
    tick(3);
    chk("rst_count", cnt8, 0);
    chk("rst_dir", dir8, 1);
    chk("rst_ovf", ovf8, 0);
    chk("rst_err", err8, 0);
    chk("rst_dv", dv8, 0);
    rst = 1'b0; en = 1'b1;
    wait_dv(n);
    chk("first_window_latency", n, 101);
    chk("empty_count", cnt8, 0);
`ifndef QRC_FILTER_EN
    steps(1'b1, 40, 2);
    wait_dv(n);
    chk("x4_fwd_interval", 80 + n, 100);
    chk("x4_fwd_count", cnt8, 40);
    chk("x4_fwd_dir", dir8, 1);
    chk("x4_fwd_ovf", ovf8, 0);
    chk("x4_fwd_err", err8, 0);
    chk("sat5_count", cnt5, 15);
    chk("sat5_ovf", ovf5, 1);
    wait_dv(n);
    chk("idle_window_interval", n, 100);
    chk("idle_window_count", cnt8, 0);
    chk("idle_window_dir_hold", dir8, 1);
    chk("sat5_clear_count", cnt5, 0);
    chk("sat5_clear_ovf", ovf5, 0);
    mode = 2'b00;
    steps(1'b0, 40, 2);
    wait_dv(n);
    chk("x1_rev_count", cnt8, -10);
    chk("x1_rev_dir", dir8, 0);
    chk("x1_rev_sat5_count", cnt5, -10);
    chk("x1_rev_sat5_ovf", ovf5, 0);
    mode = 2'b01;
    steps(1'b0, 40, 2);
    wait_dv(n);
    chk("x2_rev_count", cnt8, -20);
    chk("x2_rev_dir", dir8, 0);
    chk("x2_rev_sat5_count", cnt5, -16);
    chk("x2_rev_sat5_ovf", ovf5, 1);
    mode = 2'b11;
    steps(1'b1, 20, 1);
    steps(1'b0, 3, 1);
    wait_dv(n);
    chk("mixed_count", cnt8, 17);
    chk("mixed_dir", dir8, 0);
    chk("sat5_away_count", cnt5, 12);
    chk("sat5_away_ovf", ovf5, 1);
    p = (p + 2) % 4;
    set_phase();
    wait_dv(n);
    chk("illegal_err", err8, 1);
    chk("illegal_count", cnt8, 0);
    chk("illegal_dir_hold", dir8, 0);
    tick(97);
    steps(1'b1, 1, 0);
    wait_dv(n);
    chk("terminal_edge_count", cnt8, 1);
    chk("terminal_edge_dir", dir8, 1);
    chk("err_cleared", err8, 0);
    tick(98);
    steps(1'b1, 1, 0);
    wait_dv(n);
    chk("post_terminal_prev_window", cnt8, 0);
    wait_dv(n);
    chk("post_terminal_next_window", cnt8, 1);
    steps(1'b1, 4, 1);
    tick(46);
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      seen |= int'(dv8);
    end
    chk("disabled_no_dv", seen, 0);
    chk("disabled_count_hold", cnt8, 1);
    steps(1'b1, 3, 1);
    tick(5);
    en = 1'b1;
    steps(1'b0, 2, 1);
    wait_dv(n);
    chk("reenable_interval", 2 + n, 101);
    chk("reenable_count", cnt8, -2);
    chk("reenable_dir", dir8, 0);
    tick(50);
    rst = 1'b1;
    tick(1);
    chk("midrst_count", cnt8, 0);
    chk("midrst_dir", dir8, 1);
    chk("midrst_ovf", ovf8, 0);
    chk("midrst_err", err8, 0);
    chk("midrst_dv", dv8, 0);
    chk("midrst_sat5_count", cnt5, 0);
    rst = 1'b0;
`else
    a = ~a;
    tick(2);
    a = ~a;
    wait_dv(n);
    chk("glitch_count", cnt8, 0);
    chk("glitch_err", err8, 0);
    steps(1'b1, 4, 6);
    wait_dv(n);
    chk("filtered_count", cnt8, 4);
    chk("filtered_dir", dir8, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
